uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, line rate in bit/s.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; legal values are even numbers 4..32.
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-005 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd); used only when UART_RX_PARITY_EN is defined.
REQ-007 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port in_serial, input, 1, asynchronous serial line; idles high.
REQ-010 SHALL have port out_data, output, DATA_BITS, received word, LSB first on the line.
REQ-011 SHALL have port out_data_valid, output, 1, high while the holding register contains an unconsumed word.
REQ-012 SHALL have port in_data_ready, input, 1, consumer accepts the word in any cycle where it is high together with out_data_valid.
REQ-013 SHALL have ports out_frame_err, out_parity_err, output, 1 each, status flags for the held word; they are qualified by out_data_valid.
REQ-014 SHALL have port out_overrun, output, 1, one-cycle pulse when a completed word is dropped.

Function
REQ-015 SHALL pass in_serial through a 2-flop synchroniser; all logic uses only the synchronised value.
REQ-016 SHALL generate a sample tick every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks (integer division) using a free-running counter 0..DIV-1; elaboration SHALL fail if DIV < 1.
REQ-017 SHALL implement the states IDLE, START, DATA, PARITY and STOP; PARITY exists only with UART_RX_PARITY_EN defined.
REQ-018 IDLE SHALL move to START on the first tick where the synchronised line is 0, and SHALL clear the sample counter.
REQ-019 Each bit value SHALL be the 2-of-3 majority of the ticks at sample counts M-1, M and M+1, where M = OVERSAMPLE/2.
REQ-020 START SHALL return to IDLE with no flags when the voted start bit is 1 (false start); otherwise it SHALL move to DATA at sample count OVERSAMPLE-1.
REQ-021 DATA SHALL shift in DATA_BITS voted bits, LSB first; after the last bit it SHALL move to PARITY, or to STOP when parity is not compiled in.
REQ-022 STOP SHALL vote each of the STOP_BITS stop bits; frame error is set if any stop bit votes 0.
REQ-023 After the vote of the last stop bit (count M+1), STOP SHALL go to IDLE immediately, without waiting for the end of the bit, so back-to-back frames resynchronise.
REQ-024 The completed word and its flags SHALL reach the holding register 1 clk after the final vote; out_data_valid rises in that same cycle.
REQ-025 out_data_valid SHALL stay high until a cycle where in_data_ready=1, and SHALL be low from the next cycle.
REQ-026 If a word completes while valid=1 and ready=0, the new word SHALL be discarded, the held word retained, and out_overrun pulsed for 1 cycle.
REQ-027 If a word completes in the same cycle valid=1 and ready=1, the new word SHALL be loaded, valid SHALL stay 1, and out_overrun SHALL stay 0.
REQ-028 A word with a frame error SHALL still be delivered, with out_frame_err=1.

Reset
REQ-029 When rst=1 at a clock edge: state IDLE, synchroniser flops 1, all counters 0, out_data 0, and every flag and valid output 0.
REQ-030 Asserting rst mid-frame SHALL abandon the frame; no valid and no overrun SHALL be produced for it.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: one parity bit follows the data; out_parity_err=1 when the XOR of the data bits and the parity bit is not equal to PARITY_ODD.
REQ-032 Macro UART_RX_PARITY_EN undefined: there is no parity bit and out_parity_err is tied to 0.

Verification (CLK_FREQ=32_000_000, BAUD_RATE=1_000_000, OVERSAMPLE=16 -> DIV=2, 32 clk/bit)
REQ-033 Send 0xA5 8N1 with ready held 1 -> out_data=0xA5, valid high for 1 cycle, all flags 0.
REQ-034 Drive a 0 pulse of 8 clk on an idle line -> no valid; the next frame 0x3C is received correctly.
REQ-035 Send 0x55 with stop bit 0 -> out_data=0x55, out_frame_err=1.
REQ-036 Hold ready=0 and send 0x11 then 0x22 back-to-back -> out_data=0x11 retained, out_overrun pulses once; raising ready then drops valid.
REQ-037 With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 -> out_parity_err=1; with parity bit 1 -> out_parity_err=0.
REQ-038 Assert rst for 1 clk during data bit 3 of 0xFF -> no valid; the next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg_if.sv
// ============================================================================
// Module      : uart_rx_cfg_if
// Description : Word-delivery bundle between uart_rx_cfg and its consumer.
//               The receiver drives the held word, its status flags and the
//               overrun pulse. The consumer drives in_data_ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] out_data;
    logic                 out_data_valid;
    logic                 in_data_ready;
    logic                 out_frame_err;
    logic                 out_parity_err;
    logic                 out_overrun;

    // Receiver side
    modport master (
        output out_data,
        output out_data_valid,
        input  in_data_ready,
        output out_frame_err,
        output out_parity_err,
        output out_overrun
    );

    // Consumer side
    modport slave (
        input  out_data,
        input  out_data_valid,
        output in_data_ready,
        input  out_frame_err,
        input  out_parity_err,
        input  out_overrun
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx_cfg.sv
// ============================================================================
// Module      : uart_rx_cfg
// Description : Oversampling UART receiver with a 2-of-3 majority vote per
//               bit. It has a one-word holding register with a valid/ready
//               handshake, frame and parity flags, and an overrun pulse.
//               Optional feature macro: UART_RX_PARITY_EN adds one parity
//               bit after the data bits, checked against PARITY_ODD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_cfg #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      in_serial,
    uart_rx_cfg_if.master  rx_if
);

    localparam int C_DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int C_DIV_W  = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam int C_M      = OVERSAMPLE / 2;
    localparam int C_SAMP_W = $clog2(OVERSAMPLE);
    localparam int C_BIT_W  = $clog2(DATA_BITS);

    localparam logic [C_DIV_W-1:0]  C_DIV_LAST  = C_DIV_W'(C_DIV - 1);
    localparam logic [C_SAMP_W-1:0] C_SAMP_M1   = C_SAMP_W'(C_M - 1);
    localparam logic [C_SAMP_W-1:0] C_SAMP_M    = C_SAMP_W'(C_M);
    localparam logic [C_SAMP_W-1:0] C_SAMP_VOTE = C_SAMP_W'(C_M + 1);
    localparam logic [C_SAMP_W-1:0] C_SAMP_LAST = C_SAMP_W'(OVERSAMPLE - 1);
    localparam logic [C_BIT_W-1:0]  C_BIT_LAST  = C_BIT_W'(DATA_BITS - 1);
    localparam logic                C_STOP_LAST = 1'(STOP_BITS - 1);

    // Reject parameter sets the datapath cannot represent
    if (C_DIV < 1) begin : g_div_check
        $error("uart_rx_cfg: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be >= 1");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE > 32) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
        $error("uart_rx_cfg: OVERSAMPLE must be even in 4..32");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_db_check
        $error("uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_sb_check
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_po_check
        $error("uart_rx_cfg: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic                 sync1_q, sync2_q;
    logic [C_DIV_W-1:0]   div_q;
    state_t               state_q, state_d;
    logic [C_SAMP_W-1:0]  samp_q, samp_d;
    logic [C_BIT_W-1:0]   bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [1:0]           vote_q, vote_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 ferr_q, ferr_d;
    logic                 w_done;
    logic                 w_perr;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 frame_err_q;
    logic                 parity_err_q;
    logic                 overrun_q;

    wire logic w_line = sync2_q;
    wire logic w_tick = (div_q == C_DIV_LAST);
    // Majority of the samples at M-1 and M and the live sample at M+1
    wire logic w_vote = (vote_q[0] & vote_q[1]) | (vote_q[0] & w_line) | (vote_q[1] & w_line);
    wire logic w_at_m1   = (samp_q == C_SAMP_M1);
    wire logic w_at_m    = (samp_q == C_SAMP_M);
    wire logic w_at_vote = (samp_q == C_SAMP_VOTE);
    wire logic w_at_end  = (samp_q == C_SAMP_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    assign w_perr = ((^shreg_q) ^ par_q) != 1'(PARITY_ODD);
`else
    assign w_perr = 1'b0;
`endif

    // Two-flop synchroniser for the asynchronous line, idling high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= in_serial;
            sync2_q <= sync1_q;
        end
    end

    // Free-running divider producing one sample tick every C_DIV clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (w_tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // Frame FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            samp_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            vote_q  <= 2'b00;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            vote_q  <= vote_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic: everything advances only on sample ticks
    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        vote_d  = vote_q;
        shreg_d = shreg_q;
        ferr_d  = ferr_q;
        w_done  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        if (w_tick) begin
            if (state_q != S_IDLE) begin
                samp_d = samp_q + 1'b1;
                if (w_at_m1) vote_d[0] = w_line;
                if (w_at_m)  vote_d[1] = w_line;
            end
            case (state_q)
                S_IDLE: begin
                    if (!w_line) begin
                        state_d = S_START;
                        samp_d  = '0;
                        bit_d   = '0;
                        stop_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                S_START: begin
                    if (w_at_vote && w_vote) begin
                        // Glitch rather than a real start bit: drop silently
                        state_d = S_IDLE;
                    end else if (w_at_end) begin
                        state_d = S_DATA;
                        samp_d  = '0;
                    end
                end
                S_DATA: begin
                    if (w_at_vote) shreg_d = {w_vote, shreg_q[DATA_BITS-1:1]};
                    if (w_at_end) begin
                        samp_d = '0;
                        if (bit_q == C_BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_at_vote) par_d = w_vote;
                    if (w_at_end) begin
                        samp_d  = '0;
                        state_d = S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_at_vote) begin
                        if (!w_vote) ferr_d = 1'b1;
                        // Leave at mid-bit so the next start edge is caught early
                        if (stop_q == C_STOP_LAST) begin
                            state_d = S_IDLE;
                            w_done  = 1'b1;
                        end
                    end
                    if (w_at_end) begin
                        samp_d = '0;
                        stop_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Holding register with valid/ready handshake and overrun detection
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (w_done) begin
                if (valid_q && !rx_if.in_data_ready) begin
                    overrun_q <= 1'b1;
                end else begin
                    data_q       <= shreg_q;
                    frame_err_q  <= ferr_d;
                    parity_err_q <= w_perr;
                    valid_q      <= 1'b1;
                end
            end else if (valid_q && rx_if.in_data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.out_data       = data_q;
    assign rx_if.out_data_valid = valid_q;
    assign rx_if.out_frame_err  = frame_err_q;
    assign rx_if.out_parity_err = parity_err_q;
    assign rx_if.out_overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
// ============================================================================
// Module      : tb_uart_rx_cfg
// Description : Scoreboard bench for uart_rx_cfg at 32 MHz / 1 Mbit/s / x16
//               (32 clocks per bit). Directed frames push expected words; a
//               negedge monitor pops and compares on each accepted word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_cfg;

    localparam int CLK_FREQ   = 32_000_000;
    localparam int BAUD_RATE  = 1_000_000;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
    localparam int BIT_CLKS   = 32;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_serial;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp        = 0;
    int   n_err        = 0;
    int   ovr_cnt      = 0;
    int   valid_cycles = 0;
    int   snap;

    uart_rx_cfg_if #(.DATA_BITS(DATA_BITS)) rx_if ();

    uart_rx_cfg #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE),
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_serial(in_serial),
        .rx_if    (rx_if)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endfunction

    function automatic logic even_par(logic [7:0] d);
        return (^d) ^ 1'(PARITY_ODD);
    endfunction

    // Monitor: count valid/overrun cycles, pop and compare each accepted word
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_if.out_overrun) ovr_cnt++;
            if (rx_if.out_data_valid) valid_cycles++;
            if (rx_if.out_data_valid && rx_if.in_data_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: actual data %0h required none", rx_if.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", 32'(rx_if.out_data), 32'(mon_e.data));
                    check("word_frame_err", 32'(rx_if.out_frame_err), 32'(mon_e.ferr));
                    check("word_parity_err", 32'(rx_if.out_parity_err), 32'(mon_e.perr));
                end
            end
        end
    end

    task automatic hold(logic v, int n);
        in_serial = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(logic [7:0] d, logic stop_v, logic par_v);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        hold(par_v, BIT_CLKS);
`else
        if (par_v === 1'bx) hold(1'b1, 0);
`endif
        hold(stop_v, BIT_CLKS);
        in_serial = 1'b1;
    endtask

    task automatic drain(string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst                  = 1'b1;
        in_serial            = 1'b1;
        rx_if.in_data_ready  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_valid", 32'(rx_if.out_data_valid), 32'd0);
        check("rst_data", 32'(rx_if.out_data), 32'd0);
        check("rst_frame_err", 32'(rx_if.out_frame_err), 32'd0);
        check("rst_parity_err", 32'(rx_if.out_parity_err), 32'd0);
        check("rst_overrun", 32'(rx_if.out_overrun), 32'd0);
        rst = 1'b0;
        hold(1'b1, 2 * BIT_CLKS);

        // Clean 0xA5 with ready held high: one valid cycle
        snap = valid_cycles;
        exp_q.push_back('{data: 8'hA5, ferr: 1'b0, perr: 1'b0});
        send_frame(8'hA5, 1'b1, even_par(8'hA5));
        hold(1'b1, 2 * BIT_CLKS);
        drain("a5_drain");
        check("a5_valid_cycles", 32'(valid_cycles - snap), 32'd1);

        // 8-clock glitch is a false start, then 0x3C
        snap = valid_cycles;
        hold(1'b0, 8);
        hold(1'b1, 2 * BIT_CLKS);
        check("glitch_no_valid", 32'(valid_cycles - snap), 32'd0);
        exp_q.push_back('{data: 8'h3C, ferr: 1'b0, perr: 1'b0});
        send_frame(8'h3C, 1'b1, even_par(8'h3C));
        hold(1'b1, 2 * BIT_CLKS);
        drain("3c_drain");

        // Stop bit low: word still delivered, with frame error
        exp_q.push_back('{data: 8'h55, ferr: 1'b1, perr: 1'b0});
        send_frame(8'h55, 1'b0, even_par(8'h55));
        hold(1'b1, 3 * BIT_CLKS);
        drain("55_drain");

        // Overrun: ready low, 0x11 held, 0x22 dropped
        rx_if.in_data_ready = 1'b0;
        snap = ovr_cnt;
        exp_q.push_back('{data: 8'h11, ferr: 1'b0, perr: 1'b0});
        send_frame(8'h11, 1'b1, even_par(8'h11));
        send_frame(8'h22, 1'b1, even_par(8'h22));
        hold(1'b1, 2 * BIT_CLKS);
        check("ovr_pulses", 32'(ovr_cnt - snap), 32'd1);
        check("ovr_valid_held", 32'(rx_if.out_data_valid), 32'd1);
        check("ovr_data_held", 32'(rx_if.out_data), 32'h11);
        rx_if.in_data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_dropped", 32'(rx_if.out_data_valid), 32'd0);
        hold(1'b1, 4);
        drain("ovr_drain");

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: parity bit 0 is wrong, 1 is right (even sense)
        exp_q.push_back('{data: 8'h07, ferr: 1'b0, perr: 1'b1});
        send_frame(8'h07, 1'b1, 1'b0);
        hold(1'b1, 2 * BIT_CLKS);
        exp_q.push_back('{data: 8'h07, ferr: 1'b0, perr: 1'b0});
        send_frame(8'h07, 1'b1, 1'b1);
        hold(1'b1, 2 * BIT_CLKS);
        drain("par_drain");
`endif

        // Reset pulse in data bit 3 of 0xFF abandons the frame
        snap = valid_cycles + ovr_cnt;
        hold(1'b0, BIT_CLKS);
        hold(1'b1, 3 * BIT_CLKS + BIT_CLKS / 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(1'b1, BIT_CLKS / 2 + 7 * BIT_CLKS);
        check("rst_mid_no_word", 32'(valid_cycles + ovr_cnt - snap), 32'd0);
        exp_q.push_back('{data: 8'h81, ferr: 1'b0, perr: 1'b0});
        send_frame(8'h81, 1'b1, even_par(8'h81));
        hold(1'b1, 2 * BIT_CLKS);
        drain("81_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
